ex_mem_buffer: RTL

//  Pipeline register between EX and MEM. Captures EX results and control for the MEM stage,

---
 rtl/ex_mem_buffer_pkg.sv | 45 ++++
 rtl/ex_mem_buffer_pipe_reg.sv | 21 ++
 rtl/ex_mem_buffer.sv | 96 +++++++++
 3 files changed

// File: rtl/ex_mem_buffer_pkg.sv
// Shared constants for the EX/MEM pipeline buffer: control layout,
// stack-pointer source encodings and interrupt-entry FSM states.
package ex_mem_buffer_pkg;

  localparam int CTRL_WIDTH = 14;

  // Control bit positions, MSB first:
  // {SP_src[1:0],port_write,port_read,mem_write,mem_read,reglow_write,
  //  reghigh_write,mem_type,memToReg,mem_data_src,mem_addr_src,
  //  PC_push_pop,flags_push_pop}
  localparam int CB_FLAGS_PP   = 0;
  localparam int CB_PC_PP      = 1;
  localparam int CB_ADDR_SRC   = 2;
  localparam int CB_DATA_SRC   = 3;
  localparam int CB_MEM2REG    = 4;
  localparam int CB_MEM_TYPE   = 5;
  localparam int CB_REGHI_WR   = 6;
  localparam int CB_REGLO_WR   = 7;
  localparam int CB_MEM_RD     = 8;
  localparam int CB_MEM_WR     = 9;
  localparam int CB_PORT_RD    = 10;
  localparam int CB_PORT_WR    = 11;
  localparam int CB_SP_LO      = 12;
  localparam int CB_SP_HI      = 13;

  localparam logic [1:0] SP_HOLD = 2'd0;
  localparam logic [1:0] SP_DEC  = 2'd1;
  localparam logic [1:0] SP_INC  = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INT1 = 2'd1;
  localparam logic [1:0] ST_INT2 = 2'd2;

  // Control word MEM needs to push the return PC onto the stack.
  function automatic logic [CTRL_WIDTH-1:0] push_ctrl();
    logic [CTRL_WIDTH-1:0] c;
    c = '0;
    c[CB_MEM_WR]          = 1'b1;
    c[CB_ADDR_SRC]        = 1'b1;
    c[CB_DATA_SRC]        = 1'b1;
    c[CB_SP_HI:CB_SP_LO]  = SP_DEC;
    return c;
  endfunction

endpackage

// File: rtl/ex_mem_buffer_pipe_reg.sv
// Generic pipeline register: async active-low reset, synchronous clear
// (wins over enable), load on enable, otherwise hold.
module ex_mem_buffer_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear has priority so a bubble can be forced even while loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/ex_mem_buffer.sv
// EX/MEM pipeline buffer: captures EX results, holds on MEM stall,
// bubbles on flush and sequences the two-cycle interrupt PC push.
module ex_mem_buffer
  import ex_mem_buffer_pkg::*;
#(
  parameter int CTRL_W = CTRL_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              INT_req_in,
  input  logic [31:0]       PC_in,
  input  logic [2:0]        Rdst1_in,
  input  logic [2:0]        Rdst2_in,
  input  logic [2:0]        Rsrc_in,
  input  logic [15:0]       Rdst1_val_in,
  input  logic [15:0]       Rdst2_val_in,
  input  logic [15:0]       Rsrc_val_in,
  input  logic [15:0]       Rdst_val_in,
  input  logic [3:0]        PORT_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [31:0]       PC_out,
  output logic [2:0]        Rdst1_out,
  output logic [2:0]        Rdst2_out,
  output logic [2:0]        Rsrc_out,
  output logic [15:0]       Rdst1_val_out,
  output logic [15:0]       Rdst2_val_out,
  output logic [15:0]       Rsrc_val_out,
  output logic [15:0]       Rdst_val_out,
  output logic [3:0]        PORT_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              INT_out,
  output logic              valid_out,
  output logic              busy_out
);

  localparam int DATA_W = 32 + 3*3 + 16*4 + 4;

  logic [1:0]        state;
  logic              int_pending;
  logic              idle, int_go, int_end, capture;
  logic [DATA_W-1:0] data_d, data_q;
  logic [CTRL_W-1:0] ctrl_d;

  assign idle    = (state == ST_IDLE);
  assign int_go  = idle & int_pending & ~stall_in & ~flush_in;
  assign int_end = (state == ST_INT2);
  assign capture = idle & ~int_go & ~stall_in & ~flush_in;

  assign INT_out  = ~idle;
  assign busy_out = ~idle | int_go;

  // Interrupt-entry FSM: one-shot walk IDLE -> INT1 -> INT2 -> IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else begin
      case (state)
        ST_IDLE: if (int_go) state <= ST_INT1;
        ST_INT1: state <= ST_INT2;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pending request: set only in IDLE so requests during a sequence merge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      int_pending <= 1'b0;
    else if (int_go) int_pending <= 1'b0;
    else if (idle && INT_req_in) int_pending <= 1'b1;
  end

  assign data_d = {PC_in, Rdst1_in, Rdst2_in, Rsrc_in, Rdst1_val_in,
                   Rdst2_val_in, Rsrc_val_in, Rdst_val_in, PORT_in};
  assign {PC_out, Rdst1_out, Rdst2_out, Rsrc_out, Rdst1_val_out,
          Rdst2_val_out, Rsrc_val_out, Rdst_val_out, PORT_out} = data_q;

  // Entering the sequence swaps in the push word; data (return PC) holds.
  assign ctrl_d = int_go ? push_ctrl() : ctrl_in;

  ex_mem_buffer_pipe_reg #(.W(DATA_W)) u_data (
    .clk(clk), .rst_n(reset), .en(capture), .clr(1'b0),
    .d(data_d), .q(data_q)
  );

  ex_mem_buffer_pipe_reg #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .rst_n(reset), .en(capture | int_go), .clr(flush_in | int_end),
    .d(ctrl_d), .q(ctrl_out)
  );

  ex_mem_buffer_pipe_reg #(.W(1)) u_valid (
    .clk(clk), .rst_n(reset), .en(capture | int_go), .clr(flush_in | int_end),
    .d(1'b1), .q(valid_out)
  );

endmodule
